// File: rtl/dcache_port_arbiter_pkg.sv
// rtl/dcache_port_arbiter_pkg.sv - shared types for the D$ port arbiter (optional DCP_STORE_FWD_EN)
`ifndef LSQSZ
`define LSQSZ 16
`endif

package dcache_port_arbiter_pkg;

  localparam int LD_TAG_W_DEF = $clog2(`LSQSZ);

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } dcp_size_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } wb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } dcp_state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } dc_req_t;

  // Hazard granularity is the 8-byte block: any size, any offset inside it.
  function automatic logic same_block(input logic [15:0] a, input logic [15:0] b);
    return a[15:3] == b[15:3];
  endfunction

endpackage

// File: rtl/dcp_write_buffer.sv
// rtl/dcp_write_buffer.sv - store write-buffer FIFO with block-match and (DCP_STORE_FWD_EN) exact-match lookup
module dcp_write_buffer
  import dcache_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic [15:0]      lkp_addr_i,
`ifdef DCP_STORE_FWD_EN
  input  logic [1:0]       lkp_size_i,
  output logic             fwd_hit_o,
  output logic [63:0]      fwd_data_o,
`endif
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             blk_hit_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_i) count_q <= count_q - 1'b1;
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Walk oldest to youngest so the last exact match seen is the youngest.
  always_comb begin
    blk_hit_o  = 1'b0;
    idx        = '0;
`ifdef DCP_STORE_FWD_EN
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        if (same_block(mem_q[idx].addr, lkp_addr_i)) blk_hit_o = 1'b1;
`ifdef DCP_STORE_FWD_EN
        if (mem_q[idx].addr == lkp_addr_i && mem_q[idx].size == lkp_size_i) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = mem_q[idx].data;
        end
`endif
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - single D$ port owner: write buffer drains vs loads (store forwarding under DCP_STORE_FWD_EN)
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter  int WB_DEPTH   = 4,
  parameter  int STARVE_MAX = 8,
  parameter  int LD_TAG_W   = LD_TAG_W_DEF,
  localparam int CNT_W      = $clog2(WB_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                except_i,
  input  logic                st_valid_i,
  input  logic [15:0]         st_addr_i,
  input  logic [63:0]         st_data_i,
  input  logic [1:0]          st_size_i,
  output logic                st_ready_o,
  input  logic                ld_valid_i,
  input  logic [15:0]         ld_addr_i,
  input  logic [1:0]          ld_size_i,
  input  logic [LD_TAG_W-1:0] ld_tag_i,
  output logic                ld_ready_o,
  output logic                ld_resp_valid_o,
  output logic [LD_TAG_W-1:0] ld_resp_tag_o,
  output logic [63:0]         ld_resp_data_o,
  output logic                dc_req_valid_o,
  input  logic                dc_req_ready_i,
  output logic                dc_req_we_o,
  output logic [15:0]         dc_req_addr_o,
  output logic [63:0]         dc_req_data_o,
  output logic [1:0]          dc_req_size_o,
  input  logic                dc_resp_valid_i,
  input  logic [63:0]         dc_resp_data_i,
  output logic [CNT_W-1:0]    wb_count_o
);

  localparam int STV_W = $clog2(STARVE_MAX + 1);

  dcp_state_e          state_q;
  dc_req_t             req_q;
  logic [LD_TAG_W-1:0] req_tag_q;
  logic                squash_q;
  logic [STV_W-1:0]    starve_q;
  logic [STV_W-1:0]    starve_d;
  logic                ld_resp_valid_q;
  logic [LD_TAG_W-1:0] ld_resp_tag_q;
  logic [63:0]         ld_resp_data_q;

  wb_entry_t  wb_push_entry;
  wb_entry_t  wb_head;
  logic       wb_push, wb_pop, wb_full, wb_empty, wb_blk_hit;
  logic       force_st, grant_ld, grant_st, fwd_ld, issue;
`ifdef DCP_STORE_FWD_EN
  logic        fwd_hit;
  logic [63:0] fwd_data;
`endif

  assign wb_push_entry = '{addr: st_addr_i, data: st_data_i, size: st_size_i};
  assign wb_push       = st_valid_i & ~wb_full;
  // The head entry is only retired once D$ acknowledges it, so it keeps guarding hazards.
  assign wb_pop        = (state_q == S_WAIT) & dc_resp_valid_i & req_q.we;

  dcp_write_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (wb_push),
    .push_entry_i (wb_push_entry),
    .pop_i        (wb_pop),
    .lkp_addr_i   (ld_addr_i),
`ifdef DCP_STORE_FWD_EN
    .lkp_size_i   (ld_size_i),
    .fwd_hit_o    (fwd_hit),
    .fwd_data_o   (fwd_data),
`endif
    .head_o       (wb_head),
    .full_o       (wb_full),
    .empty_o      (wb_empty),
    .blk_hit_o    (wb_blk_hit),
    .count_o      (wb_count_o)
  );

  always_comb begin
    force_st = ~wb_empty & (wb_full | (starve_q >= STV_W'(STARVE_MAX)));
    grant_ld = 1'b0;
    grant_st = 1'b0;
    fwd_ld   = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef DCP_STORE_FWD_EN
      fwd_ld   = ld_valid_i & ~except_i & ~force_st & fwd_hit;
`endif
      grant_ld = ld_valid_i & ~except_i & ~force_st & ~wb_blk_hit;
      grant_st = ~wb_empty & ~grant_ld;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_st)
      starve_d = '0;
    else if (grant_ld && !wb_empty && starve_q < STV_W'(STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      req_q           <= '0;
      req_tag_q       <= '0;
      squash_q        <= 1'b0;
      starve_q        <= '0;
      ld_resp_valid_q <= 1'b0;
      ld_resp_tag_q   <= '0;
      ld_resp_data_q  <= '0;
    end else begin
      starve_q        <= starve_d;
      ld_resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_ld) begin
            req_q     <= '{we: 1'b0, addr: ld_addr_i, data: 64'd0, size: ld_size_i};
            req_tag_q <= ld_tag_i;
            state_q   <= S_ISSUE;
          end else if (grant_st) begin
            req_q   <= '{we: 1'b1, addr: wb_head.addr, data: wb_head.data, size: wb_head.size};
            state_q <= S_ISSUE;
          end
          if (fwd_ld) begin
`ifdef DCP_STORE_FWD_EN
            ld_resp_valid_q <= 1'b1;
            ld_resp_tag_q   <= ld_tag_i;
            ld_resp_data_q  <= fwd_data;
`endif
          end
        end
        S_ISSUE: begin
          if (except_i && !req_q.we) squash_q <= 1'b1;
          if (dc_req_ready_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (except_i && !req_q.we) squash_q <= 1'b1;
          if (dc_resp_valid_i) begin
            state_q  <= S_IDLE;
            squash_q <= 1'b0;
            if (!req_q.we) begin
              ld_resp_valid_q <= ~squash_q & ~except_i;
              ld_resp_tag_q   <= req_tag_q;
              ld_resp_data_q  <= dc_resp_data_i;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue           = (state_q == S_ISSUE);
  assign dc_req_valid_o  = issue;
  assign dc_req_we_o     = issue & req_q.we;
  assign dc_req_addr_o   = issue ? req_q.addr : 16'd0;
  assign dc_req_data_o   = issue ? req_q.data : 64'd0;
  assign dc_req_size_o   = issue ? req_q.size : 2'd0;
  assign st_ready_o      = rst_ni & ~wb_full;
  assign ld_ready_o      = rst_ni & (grant_ld | fwd_ld);
  assign ld_resp_valid_o = ld_resp_valid_q;
  assign ld_resp_tag_o   = ld_resp_tag_q;
  assign ld_resp_data_o  = ld_resp_data_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - directed self-checking bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, except_s;
  logic        st_valid, st_ready, ld_valid, ld_ready;
  logic [15:0] st_addr, ld_addr, dc_req_addr;
  logic [63:0] st_data, dc_req_data, dc_resp_data, ld_resp_data;
  logic [1:0]  st_size, ld_size, dc_req_size;
  logic [3:0]  ld_tag, ld_resp_tag;
  logic        ld_resp_valid, dc_req_valid, dc_req_ready, dc_req_we, dc_resp_valid;
  logic [2:0]  wb_count;

  int checks = 0;
  int errors = 0;
  int st_hs  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (dc_req_valid && dc_req_ready && dc_req_we) st_hs++;

  dcache_port_arbiter #(.WB_DEPTH(4), .STARVE_MAX(8), .LD_TAG_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .except_i(except_s),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_size_i(st_size),
    .st_ready_o(st_ready),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_size_i(ld_size), .ld_tag_i(ld_tag),
    .ld_ready_o(ld_ready),
    .ld_resp_valid_o(ld_resp_valid), .ld_resp_tag_o(ld_resp_tag), .ld_resp_data_o(ld_resp_data),
    .dc_req_valid_o(dc_req_valid), .dc_req_ready_i(dc_req_ready), .dc_req_we_o(dc_req_we),
    .dc_req_addr_o(dc_req_addr), .dc_req_data_o(dc_req_data), .dc_req_size_o(dc_req_size),
    .dc_resp_valid_i(dc_resp_valid), .dc_resp_data_i(dc_resp_data),
    .wb_count_o(wb_count)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a D$ request, accepts it and returns a completion one cycle later.
  task automatic dc_serve(input logic [63:0] rdata, output logic we, output logic [15:0] addr,
                          output logic [63:0] data, output logic ok);
    ok = 1'b0; we = 1'b0; addr = '0; data = '0;
    dc_req_ready = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (dc_req_valid) begin
        ok = 1'b1; we = dc_req_we; addr = dc_req_addr; data = dc_req_data;
      end
      cyc;
    end
    dc_req_ready = 1'b0;
    if (ok) begin
      dc_resp_data  = rdata;
      dc_resp_valid = 1'b1;
      cyc;
      dc_resp_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; except_s = 0; st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
    ld_valid = 1; ld_addr = 16'h5000; ld_size = 3; ld_tag = 0;
    dc_req_ready = 0; dc_resp_valid = 0; dc_resp_data = 0;
    cyc; cyc; #1;
    if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_req_valid got %b exp 0", dc_req_valid); end
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready got %b exp 0", st_ready); end
    checks++;
    if (ld_resp_valid !== 1'b0 || wb_count !== 3'd0) begin
      errors++; $display("FAIL reset_resp_count got %b/%0d exp 0/0", ld_resp_valid, wb_count);
    end
    checks++;
    ld_valid = 0;
    rst_n = 1'b1;
    #1;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL post_reset_st_ready got %b exp 1", st_ready); end
    checks++;
    cyc;
  endtask

  task automatic test_single_store;
    int hs0;
    hs0 = st_hs;
    st_valid = 1; st_addr = 16'h0100; st_data = 64'h11; st_size = 3; dc_req_ready = 1;
    #1;
    if (st_ready !== 1'b1 || wb_count !== 3'd0) begin
      errors++; $display("FAIL st1_before_push got %b/%0d exp 1/0", st_ready, wb_count);
    end
    checks++;
    cyc; st_valid = 0; #1;
    if (wb_count !== 3'd1 || dc_req_valid !== 1'b0) begin
      errors++; $display("FAIL st1_pushed got cnt %0d req %b exp 1/0", wb_count, dc_req_valid);
    end
    checks++;
    cyc;
    if (dc_req_valid !== 1'b1 || dc_req_we !== 1'b1 || dc_req_addr !== 16'h0100 || dc_req_data !== 64'h11 || dc_req_size !== 2'd3) begin
      errors++; $display("FAIL st1_issue got v%b we%b a%h d%h s%0d exp 1 1 0100 11 3",
                         dc_req_valid, dc_req_we, dc_req_addr, dc_req_data, dc_req_size);
    end
    checks++;
    cyc;
    if (dc_req_valid !== 1'b0 || wb_count !== 3'd1) begin
      errors++; $display("FAIL st1_wait got req %b cnt %0d exp 0/1", dc_req_valid, wb_count);
    end
    checks++;
    cyc; dc_resp_valid = 1; #1;
    if (wb_count !== 3'd1) begin errors++; $display("FAIL st1_before_ack got %0d exp 1", wb_count); end
    checks++;
    cyc; dc_resp_valid = 0; dc_req_ready = 0; #1;
    if (wb_count !== 3'd0 || ld_resp_valid !== 1'b0) begin
      errors++; $display("FAIL st1_acked got cnt %0d ldv %b exp 0/0", wb_count, ld_resp_valid);
    end
    checks++;
    if (st_hs - hs0 !== 1) begin errors++; $display("FAIL st1_handshakes got %0d exp 1", st_hs - hs0); end
    checks++;
  endtask

  task automatic test_wb_full;
    logic we, ok; logic [15:0] a; logic [63:0] d;
    dc_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1; st_addr = 16'h0200 + 16'(8 * i); st_data = 64'(i + 1); st_size = 3;
      cyc;
    end
    st_addr = 16'h0220; st_data = 64'd5;
    #1;
    if (st_ready !== 1'b0 || wb_count !== 3'd4) begin
      errors++; $display("FAIL full_ready got %b cnt %0d exp 0/4", st_ready, wb_count);
    end
    checks++;
    cyc; cyc; #1;
    if (wb_count !== 3'd4 || dc_req_valid !== 1'b1 || dc_req_addr !== 16'h0200) begin
      errors++; $display("FAIL full_held got cnt %0d v %b a %h exp 4 1 0200", wb_count, dc_req_valid, dc_req_addr);
    end
    checks++;
    dc_serve(64'd0, we, a, d, ok);
    if (ok !== 1'b1 || we !== 1'b1 || d !== 64'd1) begin
      errors++; $display("FAIL full_drain1 got ok %b we %b d %0d exp 1 1 1", ok, we, d);
    end
    checks++;
    #1;
    if (wb_count !== 3'd3 || st_ready !== 1'b1) begin
      errors++; $display("FAIL full_after_ack got cnt %0d rdy %b exp 3/1", wb_count, st_ready);
    end
    checks++;
    cyc; st_valid = 0; #1;
    if (wb_count !== 3'd4) begin errors++; $display("FAIL full_fifth_pushed got %0d exp 4", wb_count); end
    checks++;
    for (int j = 2; j <= 5; j++) begin
      dc_serve(64'd0, we, a, d, ok);
      if (ok !== 1'b1 || we !== 1'b1 || d !== 64'(j) || a !== 16'h0200 + 16'(8 * (j - 1))) begin
        errors++; $display("FAIL full_drain%0d got ok %b we %b a %h d %0d exp 1 1 %h %0d",
                           j, ok, we, a, d, 16'h0200 + 16'(8 * (j - 1)), j);
      end
      checks++;
    end
    #1;
    if (wb_count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", wb_count); end
    checks++;
  endtask

  task automatic test_starve;
    logic we, ok; logic [15:0] a; logic [63:0] d; logic [3:0] etag;
    dc_req_ready = 0;
    st_valid = 1; st_addr = 16'h0100; st_data = 64'hAA; st_size = 3;
    ld_valid = 1; ld_addr = 16'h2000; ld_size = 3; ld_tag = 0;
    #1;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL starve_first_load got %b exp 1", ld_ready); end
    checks++;
    cyc; st_valid = 0;
    for (int s = 0; s <= 10; s++) begin
      dc_serve(64'h1000 + 64'(s), we, a, d, ok);
      if (s == 9) begin
        #1;
        if (ok !== 1'b1 || we !== 1'b1 || a !== 16'h0100 || d !== 64'hAA || wb_count !== 3'd0) begin
          errors++; $display("FAIL starve_forced_store got ok %b we %b a %h d %h cnt %0d exp 1 1 0100 aa 0",
                             ok, we, a, d, wb_count);
        end
        checks++;
      end else begin
        etag = (s < 9) ? 4'(s) : 4'd9;
        if (ok !== 1'b1 || we !== 1'b0 || a !== 16'h2000 + 16'(8 * etag) ||
            ld_resp_valid !== 1'b1 || ld_resp_tag !== etag || ld_resp_data !== 64'h1000 + 64'(s)) begin
          errors++; $display("FAIL starve_load%0d got ok %b we %b a %h rv %b tag %0d data %h exp 1 0 %h 1 %0d %h",
                             s, ok, we, a, ld_resp_valid, ld_resp_tag, ld_resp_data,
                             16'h2000 + 16'(8 * etag), etag, 64'h1000 + 64'(s));
        end
        checks++;
      end
      if (s < 9) begin
        ld_addr = 16'h2000 + 16'(8 * (s + 1)); ld_tag = 4'(s + 1);
      end
      if (s == 8) begin
        #1;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL starve_block_ld got %b exp 0", ld_ready); end
        checks++;
      end
      if (s == 10) ld_valid = 0;
    end
  endtask

  task automatic test_overlap;
    logic we, ok; logic [15:0] a; logic [63:0] d;
    dc_req_ready = 0;
    ld_valid = 1; ld_addr = 16'h3000; ld_size = 3; ld_tag = 1;
    cyc;
    ld_addr = 16'h010C; ld_size = 2; ld_tag = 2;
    st_valid = 1; st_addr = 16'h0108; st_data = 64'h55; st_size = 3;
    cyc; st_valid = 0;
    dc_serve(64'h33, we, a, d, ok);
    #1;
    if (ok !== 1'b1 || we !== 1'b0 || a !== 16'h3000 || ld_resp_tag !== 4'd1) begin
      errors++; $display("FAIL ovl_first_load got ok %b we %b a %h tag %0d exp 1 0 3000 1", ok, we, a, ld_resp_tag);
    end
    checks++;
    if (ld_ready !== 1'b0 || wb_count !== 3'd1) begin
      errors++; $display("FAIL ovl_blocked got rdy %b cnt %0d exp 0/1", ld_ready, wb_count);
    end
    checks++;
    dc_serve(64'd0, we, a, d, ok);
    if (ok !== 1'b1 || we !== 1'b1 || a !== 16'h0108) begin
      errors++; $display("FAIL ovl_store_first got ok %b we %b a %h exp 1 1 0108", ok, we, a);
    end
    checks++;
    #1;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL ovl_unblocked got %b exp 1", ld_ready); end
    checks++;
    dc_serve(64'h44, we, a, d, ok);
    ld_valid = 0;
    if (ok !== 1'b1 || we !== 1'b0 || a !== 16'h010C || ld_resp_valid !== 1'b1 || ld_resp_tag !== 4'd2 || ld_resp_data !== 64'h44) begin
      errors++; $display("FAIL ovl_load_done got ok %b we %b a %h rv %b tag %0d d %h exp 1 0 010c 1 2 44",
                         ok, we, a, ld_resp_valid, ld_resp_tag, ld_resp_data);
    end
    checks++;
  endtask

  task automatic test_except;
    logic we, ok; logic [15:0] a; logic [63:0] d;
    ld_valid = 1; ld_addr = 16'h4000; ld_size = 3; ld_tag = 5; dc_req_ready = 1;
    cyc; ld_valid = 0;
    cyc;
    except_s = 1;
    cyc; except_s = 0;
    dc_req_ready = 0; dc_resp_valid = 1; dc_resp_data = 64'h77;
    cyc; dc_resp_valid = 0; #1;
    if (ld_resp_valid !== 1'b0 || dc_req_valid !== 1'b0) begin
      errors++; $display("FAIL exc_suppressed got rv %b req %b exp 0/0", ld_resp_valid, dc_req_valid);
    end
    checks++;
    ld_valid = 1; ld_addr = 16'h4008; ld_tag = 6; except_s = 1; #1;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL exc_ld_ready got %b exp 0", ld_ready); end
    checks++;
    except_s = 0; #1;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL exc_idle_again got %b exp 1", ld_ready); end
    checks++;
    dc_serve(64'h88, we, a, d, ok);
    ld_valid = 0;
    if (ok !== 1'b1 || a !== 16'h4008 || ld_resp_valid !== 1'b1 || ld_resp_tag !== 4'd6 || ld_resp_data !== 64'h88) begin
      errors++; $display("FAIL exc_next_load got ok %b a %h rv %b tag %0d d %h exp 1 4008 1 6 88",
                         ok, a, ld_resp_valid, ld_resp_tag, ld_resp_data);
    end
    checks++;
  endtask

`ifdef DCP_STORE_FWD_EN
  task automatic test_forward;
    logic we, ok; logic [15:0] a; logic [63:0] d;
    dc_req_ready = 0;
    st_valid = 1; st_addr = 16'h0040; st_data = 64'hDEAD; st_size = 3;
    cyc; st_valid = 0;
    ld_valid = 1; ld_addr = 16'h0040; ld_size = 3; ld_tag = 7; #1;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got %b exp 1", ld_ready); end
    checks++;
    cyc; ld_valid = 0; #1;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== 64'hDEAD || ld_resp_tag !== 4'd7 || dc_req_we !== 1'b1) begin
      errors++; $display("FAIL fwd_resp got rv %b d %h tag %0d we %b exp 1 dead 7 1",
                         ld_resp_valid, ld_resp_data, ld_resp_tag, dc_req_we);
    end
    checks++;
    dc_serve(64'd0, we, a, d, ok);
  endtask
`endif

  task automatic test_reset_midop;
    dc_req_ready = 0;
    st_valid = 1; st_addr = 16'h0600; st_data = 64'h9; st_size = 3;
    cyc; cyc; st_valid = 0; #1;
    if (wb_count !== 3'd2 || dc_req_valid !== 1'b1) begin
      errors++; $display("FAIL midop_busy got cnt %0d req %b exp 2/1", wb_count, dc_req_valid);
    end
    checks++;
    rst_n = 0; #1;
    if (wb_count !== 3'd0 || dc_req_valid !== 1'b0) begin
      errors++; $display("FAIL midop_cleared got cnt %0d req %b exp 0/0", wb_count, dc_req_valid);
    end
    checks++;
    cyc; rst_n = 1; cyc; #1;
    if (wb_count !== 3'd0 || dc_req_valid !== 1'b0 || st_ready !== 1'b1) begin
      errors++; $display("FAIL midop_after got cnt %0d req %b rdy %b exp 0 0 1", wb_count, dc_req_valid, st_ready);
    end
    checks++;
  endtask

  initial begin
    test_reset;
    test_single_store;
    test_wb_full;
    test_starve;
    test_overlap;
    test_except;
`ifdef DCP_STORE_FWD_EN
    test_forward;
`endif
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
